// File: rtl/rcpu_mmio_uart.sv
`default_nettype none
// ============================================================================
// rcpu_mmio_uart : CPU memory-bus decoder with an MMIO TX-only UART (FIFO),
//                  LED register and free-running cycle counter.
// Revision 1.0
// ============================================================================
module rcpu_mmio_uart #(
  parameter int          CLKS_PER_BIT = 104,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] IO_BASE      = 16'hFF00
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic [0:15] cpu_rd_addr,
  input  logic        cpu_rd_en,
  output logic [0:15] cpu_rd_data,
  input  logic [0:15] cpu_wr_addr,
  input  logic        cpu_wr_en,
  input  logic [0:15] cpu_wr_data,
  output logic [0:15] ram_rd_addr,
  output logic        ram_rd_en,
  input  logic [0:15] ram_rd_data,
  output logic [0:15] ram_wr_addr,
  output logic        ram_wr_en,
  output logic [0:15] ram_wr_data,
  output logic        uart_tx,
  output logic [7:0]  leds
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // The core numbers bits MSB-first; all internal arithmetic uses [15:0].
  logic [15:0] rd_addr_n, wr_addr_n, wr_data_n, ram_rd_data_n;
  logic [15:0] rd_off, wr_off;
  logic        io_rd, io_wr;
  logic        unused_wr_hi;

  assign rd_addr_n     = cpu_rd_addr;
  assign wr_addr_n     = cpu_wr_addr;
  assign wr_data_n     = cpu_wr_data;
  assign ram_rd_data_n = ram_rd_data;
  assign unused_wr_hi  = ^wr_data_n[15:8];

  assign io_rd  = (rd_addr_n >= IO_BASE);
  assign io_wr  = (wr_addr_n >= IO_BASE);
  assign rd_off = rd_addr_n - IO_BASE;
  assign wr_off = wr_addr_n - IO_BASE;

  assign ram_rd_addr = cpu_rd_addr;
  assign ram_rd_en   = cpu_rd_en & ~io_rd;
  assign ram_wr_addr = cpu_wr_addr;
  assign ram_wr_data = cpu_wr_data;
  assign ram_wr_en   = cpu_wr_en & ~io_wr;

  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic          empty, full, busy;
  logic          push_req, push, pop, ovf_clr;
  logic          ovf_q;
  logic [7:0]    leds_q;
  logic [15:0]   cycles_q;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_last;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign busy  = ~empty | (state_q != S_IDLE);

  assign pop      = (state_q == S_IDLE) & ~empty;
  assign push_req = cpu_wr_en & io_wr & (wr_off == 16'd0);
  assign push     = push_req & (~full | pop);
  assign ovf_clr  = cpu_wr_en & io_wr & (wr_off == 16'd1);

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= wr_data_n[7:0];
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      leds_q   <= 8'h00;
      cycles_q <= 16'h0000;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_req && !push) ovf_q <= 1'b1;
      else if (ovf_clr)      ovf_q <= 1'b0;
      if (cpu_wr_en && io_wr && wr_off == 16'd2) leds_q <= wr_data_n[7:0];
      cycles_q <= cycles_q + 16'd1;
    end
  end

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line level is registered from the next state so the pin never glitches.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign uart_tx = tx_q;
  assign leds    = leds_q;

  logic [15:0] rd_val;
  always_comb begin
    rd_val = 16'h0000;
    if (!io_rd) begin
      rd_val = ram_rd_data_n;
    end else begin
      case (rd_off)
        16'd1:   rd_val = {12'h000, ovf_q, busy, full, empty};
        16'd2:   rd_val = {8'h00, leds_q};
        16'd3:   rd_val = cycles_q;
        default: rd_val = 16'h0000;
      endcase
    end
  end

  assign cpu_rd_data = rd_val;

endmodule
`default_nettype wire

// File: tb/tb_rcpu_mmio_uart.sv
`default_nettype none
// ============================================================================
// tb_rcpu_mmio_uart : scoreboard bench with a queue-based reference model.
// Revision 1.0
// ============================================================================
module tb_rcpu_mmio_uart;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [15:0] IOB   = 16'hFF00;
  localparam int          FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        resetq = 1'b1;
  logic [0:15] cpu_rd_addr = '0, cpu_wr_addr = '0, cpu_wr_data = '0, ram_rd_data = '0;
  logic        cpu_rd_en = 1'b0, cpu_wr_en = 1'b0;
  logic [0:15] cpu_rd_data, ram_rd_addr, ram_wr_addr, ram_wr_data;
  logic        ram_rd_en, ram_wr_en, uart_tx;
  logic [7:0]  leds;

  rcpu_mmio_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .IO_BASE(IOB)) dut (
    .clk(clk), .resetq(resetq),
    .cpu_rd_addr(cpu_rd_addr), .cpu_rd_en(cpu_rd_en), .cpu_rd_data(cpu_rd_data),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_en(cpu_wr_en), .cpu_wr_data(cpu_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_en(ram_rd_en), .ram_rd_data(ram_rd_data),
    .ram_wr_addr(ram_wr_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
    .uart_tx(uart_tx), .leds(leds)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rd;
    logic        ren;
    logic [15:0] raddr;
    logic        wen;
    logic [15:0] waddr;
    logic [15:0] wdata;
    logic [7:0]  leds;
  } exp_t;

  typedef struct {
    logic [7:0] b;
    int         start;
  } frame_t;

  exp_t       rd_q[$];
  frame_t     fr_q[$];
  logic [7:0] fifo_m[$];

  int          n_chk = 0, n_fail = 0;
  int          edge_n = 0;
  int          next_pop_ok, busy_until;
  logic        ovf_m;
  logic [7:0]  leds_m;
  logic [15:0] cyc_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] status_m();
    logic e, f, b;
    e = (fifo_m.size() == 0);
    f = (fifo_m.size() == DEPTH);
    b = (fifo_m.size() > 0) || (edge_n < busy_until);
    return {12'h000, ovf_m, b, f, e};
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a, input logic [15:0] ramd);
    if (a < IOB) return ramd;
    case (16'(a - IOB))
      16'd1:   return status_m();
      16'd2:   return {8'h00, leds_m};
      16'd3:   return cyc_m;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    fr_q.delete();
    next_pop_ok = 0;
    busy_until  = 0;
    ovf_m       = 1'b0;
    leds_m      = 8'h00;
    cyc_m       = 16'h0000;
  endtask

  // One clock edge of the model: the transmitter takes the oldest byte once it
  // has been idle for a full cycle, then the CPU write lands.
  task automatic model_edge(input logic wen, input logic [15:0] wa, input logic [15:0] wd);
    frame_t fr;
    if (edge_n >= next_pop_ok && fifo_m.size() > 0) begin
      fr.b     = fifo_m.pop_front();
      fr.start = edge_n;
      fr_q.push_back(fr);
      next_pop_ok = edge_n + FRAME + 1;
      busy_until  = edge_n + FRAME;
    end
    if (wen && wa >= IOB) begin
      case (16'(wa - IOB))
        16'd0: if (fifo_m.size() < DEPTH) fifo_m.push_back(wd[7:0]); else ovf_m = 1'b1;
        16'd1: ovf_m = 1'b0;
        16'd2: leds_m = wd[7:0];
        default: ;
      endcase
    end
    cyc_m = cyc_m + 16'd1;
  endtask

  task automatic step(input logic ren, input logic [15:0] ra, input logic wen,
                      input logic [15:0] wa, input logic [15:0] wd, input logic [15:0] rdd);
    exp_t e;
    cpu_rd_en = ren; cpu_rd_addr = ra;
    cpu_wr_en = wen; cpu_wr_addr = wa; cpu_wr_data = wd;
    ram_rd_data = rdd;
    e.rd = model_read(ra, rdd);
    e.ren = ren && (ra < IOB);
    e.raddr = ra;
    e.wen = wen && (wa < IOB);
    e.waddr = wa;
    e.wdata = wd;
    e.leds = leds_m;
    rd_q.push_back(e);
    @(posedge clk);
    edge_n++;
    if (resetq) model_edge(wen, wa, wd);
    #1;
  endtask

  task automatic idle_read(input logic [15:0] ra);
    step(1'b1, ra, 1'b0, 16'h0000, 16'h0000, 16'($urandom));
  endtask

  task automatic wr(input logic [15:0] wa, input logic [15:0] wd);
    step(1'b0, IOB + 16'd1, 1'b1, wa, wd, 16'($urandom));
  endtask

  // Monitor: bus outputs every cycle, serial frames decoded cycle by cycle.
  initial begin : monitor
    exp_t        e;
    frame_t      fr;
    logic        mon_active = 1'b0;
    logic        mon_ok = 1'b1;
    logic [7:0]  mon_b = 8'h00;
    int          mon_cnt = 0;
    int          bi;
    logic        bitv;
    forever begin
      @(negedge clk);
      if (rd_q.size() > 0) begin
        e = rd_q.pop_front();
        chk("cpu_rd_data", 32'(cpu_rd_data), 32'(e.rd));
        chk("ram_rd_en",   32'(ram_rd_en),   32'(e.ren));
        chk("ram_rd_addr", 32'(ram_rd_addr), 32'(e.raddr));
        chk("ram_wr_en",   32'(ram_wr_en),   32'(e.wen));
        chk("ram_wr_addr", 32'(ram_wr_addr), 32'(e.waddr));
        chk("ram_wr_data", 32'(ram_wr_data), 32'(e.wdata));
        chk("leds",        32'(leds),        32'(e.leds));
      end
      if (!resetq) begin
        mon_active = 1'b0;
      end else if (mon_active) begin
        mon_cnt++;
        bi = mon_cnt / CPB;
        if (bi == 0)      bitv = 1'b0;
        else if (bi <= 8) bitv = mon_b[bi-1];
        else              bitv = 1'b1;
        if (uart_tx !== bitv) mon_ok = 1'b0;
        if (mon_cnt == FRAME - 1) begin
          chk($sformatf("frame_bits_%02h", mon_b), 32'(mon_ok), 32'd1);
          mon_active = 1'b0;
        end
      end else if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt = 0;
        mon_ok = 1'b1;
        if (fr_q.size() == 0) begin
          chk("unexpected_frame_queue_size", 32'(fr_q.size()), 32'd1);
          mon_b = 8'h00;
        end else begin
          fr = fr_q.pop_front();
          mon_b = fr.b;
          chk("frame_start_edge", 32'(edge_n), 32'(fr.start));
        end
      end
    end
  end

  initial begin : driver
    logic [15:0] wa, wd, ra;
    logic        wen, ren;
    int          r, k;

    // Power-on reset
    #2 resetq = 1'b0;
    model_reset();
    @(posedge clk); #1;
    chk("tx_in_reset", 32'(uart_tx), 32'd1);
    idle_read(IOB + 16'd1);
    idle_read(IOB + 16'd3);
    resetq = 1'b1;
    idle_read(IOB + 16'd3);
    idle_read(IOB + 16'd3);
    idle_read(IOB + 16'd2);

    // Single byte 0x55 with status sampled across the frame
    wr(IOB, 16'h0055);
    for (int i = 0; i < FRAME + 4; i++) idle_read(IOB + 16'd1);

    // Overflow: six back-to-back pushes into an idle block
    for (int i = 0; i < 6; i++) wr(IOB, 16'h0041 + 16'(i));
    idle_read(IOB + 16'd1);
    step(1'b1, IOB + 16'd1, 1'b1, IOB + 16'd1, 16'h0000, 16'($urandom));
    idle_read(IOB + 16'd1);
    for (int i = 0; i < 5 * (FRAME + 1) + 5; i++) idle_read(IOB + 16'd1);

    // RAM passthrough and LED register
    step(1'b1, 16'h1234, 1'b0, 16'h0000, 16'h0000, 16'hBEEF);
    wr(IOB + 16'd2, 16'h01A5);
    idle_read(IOB + 16'd2);
    step(1'b1, 16'h0FFF, 1'b1, IOB + 16'h0010, 16'h5A5A, 16'h1357);
    step(1'b1, IOB - 16'd1, 1'b1, IOB - 16'd1, 16'hCAFE, 16'h2468);
    step(1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 16'h00FF, 16'h9999);
    wr(IOB + 16'd3, 16'h0000);
    idle_read(IOB + 16'd2);

    // Reset in the middle of a frame
    wr(IOB, 16'h0000);
    for (int i = 0; i < 8; i++) idle_read(IOB + 16'd1);
    #2 chk("tx_low_mid_frame", 32'(uart_tx), 32'd0);
    resetq = 1'b0;
    #1 chk("tx_async_reset", 32'(uart_tx), 32'd1);
    model_reset();
    @(posedge clk); edge_n++; #1;
    idle_read(IOB + 16'd1);
    idle_read(IOB + 16'd2);
    resetq = 1'b1;
    idle_read(IOB + 16'd3);
    idle_read(IOB + 16'd3);
    idle_read(IOB + 16'd1);

    // Paced pushes spanning the FIFO pointer wrap
    for (int i = 0; i < 2 * DEPTH + 1; i++) begin
      wr(IOB, 16'($urandom));
      if (i % 3 == 2) for (int j = 0; j < 3 * (FRAME + 1); j++) idle_read(IOB + 16'd1);
    end
    for (int j = 0; j < 4 * (FRAME + 1); j++) idle_read(IOB + 16'd1);

    // Randomised traffic
    for (int i = 0; i < 2500; i++) begin
      r = $urandom_range(0, 99);
      wd = 16'($urandom);
      wen = 1'b1;
      if (r < 6)       wa = IOB;
      else if (r < 9)  wa = IOB + 16'd1;
      else if (r < 13) wa = IOB + 16'd2;
      else if (r < 16) wa = IOB + 16'($urandom_range(3, 255));
      else if (r < 40) wa = 16'($urandom_range(0, 32'(IOB) - 1));
      else begin wen = 1'b0; wa = 16'($urandom); end
      k = $urandom_range(0, 7);
      if (k <= 3)      ra = IOB + 16'(k);
      else if (k == 4) ra = IOB + 16'($urandom_range(4, 255));
      else if (k == 5) ra = 16'($urandom_range(0, 32'(IOB) - 1));
      else if (k == 6) ra = IOB - 16'd1;
      else             ra = 16'hFFFF;
      ren = 1'($urandom);
      step(ren, ra, wen, wa, wd, 16'($urandom));
    end
    for (int j = 0; j < (DEPTH + 2) * (FRAME + 1); j++) idle_read(IOB + 16'd1);

    // Cycle counter wrap after a fresh reset
    resetq = 1'b0;
    model_reset();
    @(posedge clk); edge_n++; #1;
    resetq = 1'b1;
    for (int i = 0; i < 65540; i++) idle_read(IOB + 16'd3);

    chk("frames_drained", 32'(fr_q.size()), 32'd0);
    @(negedge clk);
    chk("reads_drained", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
